// File: rtl/sa_psum_accumulator_if.sv
// Stream bundle for the partial-sum accumulator: skewed per-column input beats
// and the 16-column-wide requantised output port (valid/ready).
interface sa_psum_accumulator_if #(
  parameter int COLS   = 16,
  parameter int ADDR_W = 10
);
  logic [8*COLS-1:0] accu_data;
  logic [COLS-1:0]   accu_valid;
  logic [8*COLS-1:0] out_data;
  logic [ADDR_W-1:0] out_addr;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output accu_data, accu_valid, out_ready,
    input  out_data, out_addr, out_valid
  );

  modport slave (
    input  accu_data, accu_valid, out_ready,
    output out_data, out_addr, out_valid
  );
endinterface

// File: rtl/sa_psum_accumulator.sv
// Per-pixel accumulation of skewed SA column partial sums over several passes, then a
// requantised drain. Define ACC_RELU_EN to clamp negative drained results to zero.
module sa_psum_accumulator #(
  parameter int COLS   = 16,
  parameter int DEPTH  = 784,
  parameter int ACC_W  = 16,
  parameter int ADDR_W = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [4:0]            ofmap_size_i,
  input  logic [3:0]            num_pass_i,
  input  logic [3:0]            shift_i,
  sa_psum_accumulator_if.slave  sa_if,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  state_e            state_r, state_s;
  logic [ADDR_W-1:0] p_r;
  logic [3:0]        npass_r;
  logic [3:0]        shift_r;
  logic [3:0]        pass_r;
  logic [ADDR_W-1:0] ptr_r [COLS];
  logic [ACC_W-1:0]  mem_r [COLS][DEPTH];
  logic [ADDR_W-1:0] out_addr_r;
  logic [8*COLS-1:0] out_data_r;
  logic              out_valid_r;
  logic              done_r;
  logic              busy_r;
  logic              err_r;

  logic [ADDR_W-1:0] cfg_p_s;
  logic              cfg_ok_s;
  logic [COLS-1:0]   ptr_full_s;
  logic [COLS-1:0]   acc_en_s;
  logic              all_full_s;
  logic              bad_valid_s;
  logic              last_pass_s;
  logic              xfer_s;
  logic              last_beat_s;
  logic [ADDR_W-1:0] rd_idx_s;
  logic [ACC_W-1:0]  wr_val_s [COLS];
  logic [8*COLS-1:0] drain_q_s;
  logic              err_s;

  // Saturating accumulate; the first pass simply loads the sign-extended beat.
  function automatic logic [ACC_W-1:0] acc_add(input logic [ACC_W-1:0] e,
                                               input logic [7:0] d,
                                               input logic first);
    logic [ACC_W:0] s;
    if (first) s = {{(ACC_W-7){d[7]}}, d};
    else       s = {e[ACC_W-1], e} + {{(ACC_W-7){d[7]}}, d};
    if (s[ACC_W] != s[ACC_W-1])
      return s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    else
      return s[ACC_W-1:0];
  endfunction

  // Arithmetic shift then clamp to signed 8 bits (optionally rectified).
  function automatic logic [7:0] requant(input logic [ACC_W-1:0] e, input logic [3:0] sh);
    logic signed [ACC_W-1:0] s;
    logic [7:0]              q;
    s = $signed(e) >>> sh;
    if ((&s[ACC_W-1:7]) || !(|s[ACC_W-1:7])) q = s[7:0];
    else                                     q = s[ACC_W-1] ? 8'h80 : 8'h7f;
`ifdef ACC_RELU_EN
    q = q[7] ? 8'h00 : q;
`else
    q = q;
`endif
    return q;
  endfunction

  assign cfg_p_s     = ADDR_W'(ofmap_size_i) * ADDR_W'(ofmap_size_i);
  assign cfg_ok_s    = (ofmap_size_i != 5'd0) && (int'(cfg_p_s) <= DEPTH);
  assign all_full_s  = &ptr_full_s;
  assign bad_valid_s = |(sa_if.accu_valid & ~acc_en_s);
  assign last_pass_s = (pass_r == (npass_r - 4'd1));
  assign xfer_s      = out_valid_r && sa_if.out_ready;
  assign last_beat_s = (out_addr_r == (p_r - ADDR_W'(1'b1)));
  // Prefetch the next beat while the current one is on the port so ready=1 streams at one beat per cycle.
  assign rd_idx_s    = (out_valid_r && !last_beat_s) ? out_addr_r + ADDR_W'(1'b1) : out_addr_r;

  // Next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE:  if (start_i && cfg_ok_s)         state_s = ST_ACCUM; else state_s = ST_IDLE;
      ST_ACCUM: if (all_full_s && last_pass_s)   state_s = ST_DRAIN; else state_s = ST_ACCUM;
      ST_DRAIN: if (xfer_s && last_beat_s)       state_s = ST_IDLE;  else state_s = ST_DRAIN;
      default:                                   state_s = ST_IDLE;
    endcase
  end

  // Per-column accept, read-modify-write value and drain read data.
  always_comb begin
    ptr_full_s = {COLS{1'b0}};
    acc_en_s   = {COLS{1'b0}};
    drain_q_s  = {(8*COLS){1'b0}};
    for (int c = 0; c < COLS; c++) begin
      ptr_full_s[c]      = (ptr_r[c] == p_r);
      acc_en_s[c]        = (state_r == ST_ACCUM) && sa_if.accu_valid[c] && !ptr_full_s[c];
      wr_val_s[c]        = acc_add(mem_r[c][ptr_r[c]], sa_if.accu_data[8*c +: 8], pass_r == 4'd0);
      drain_q_s[8*c +: 8] = requant(mem_r[c][rd_idx_s], shift_r);
    end
  end

  // Sticky error: a start clears it unless that start itself carries a bad config.
  always_comb begin
    if (state_r == ST_IDLE && start_i) err_s = !cfg_ok_s || bad_valid_s;
    else                               err_s = err_r || bad_valid_s;
  end

  // Control state, pointers, pass counter and registered output port.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      p_r         <= {ADDR_W{1'b0}};
      npass_r     <= 4'd0;
      shift_r     <= 4'd0;
      pass_r      <= 4'd0;
      out_addr_r  <= {ADDR_W{1'b0}};
      out_data_r  <= {(8*COLS){1'b0}};
      out_valid_r <= 1'b0;
      done_r      <= 1'b0;
      busy_r      <= 1'b0;
      err_r       <= 1'b0;
      for (int c = 0; c < COLS; c++) ptr_r[c] <= {ADDR_W{1'b0}};
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s != ST_IDLE);
      err_r   <= err_s;
      done_r  <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start_i && cfg_ok_s) begin
            p_r     <= cfg_p_s;
            npass_r <= (num_pass_i == 4'd0) ? 4'd1 : num_pass_i;
            shift_r <= shift_i;
            pass_r  <= 4'd0;
            for (int c = 0; c < COLS; c++) ptr_r[c] <= {ADDR_W{1'b0}};
          end
        end
        ST_ACCUM: begin
          if (all_full_s) begin
            for (int c = 0; c < COLS; c++) ptr_r[c] <= {ADDR_W{1'b0}};
            if (!last_pass_s) pass_r <= pass_r + 4'd1;
            out_addr_r  <= {ADDR_W{1'b0}};
            out_valid_r <= 1'b0;
          end else begin
            for (int c = 0; c < COLS; c++)
              if (acc_en_s[c]) ptr_r[c] <= ptr_r[c] + ADDR_W'(1'b1);
          end
        end
        ST_DRAIN: begin
          if (!out_valid_r) begin
            out_valid_r <= 1'b1;
            out_data_r  <= drain_q_s;
          end else if (sa_if.out_ready) begin
            if (last_beat_s) begin
              out_valid_r <= 1'b0;
              out_addr_r  <= {ADDR_W{1'b0}};
              done_r      <= 1'b1;
            end else begin
              out_addr_r <= out_addr_r + ADDR_W'(1'b1);
              out_data_r <= drain_q_s;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Partial-sum buffer; deliberately not reset.
  always_ff @(posedge clk) begin
    for (int c = 0; c < COLS; c++)
      if (acc_en_s[c]) mem_r[c][ptr_r[c]] <= wr_val_s[c];
  end

  assign sa_if.out_data  = out_data_r;
  assign sa_if.out_addr  = out_addr_r;
  assign sa_if.out_valid = out_valid_r;
  assign busy_o          = busy_r;
  assign done_o          = done_r;
  assign err_o           = err_r;

endmodule

// File: tb/tb_sa_psum_accumulator.sv
// Directed bench for sa_psum_accumulator: reference accumulation model feeds a
// scoreboard of expected drain beats that is checked as the DUT emits them.
module tb_sa_psum_accumulator;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_i;
  logic [4:0] ofmap_size_i;
  logic [3:0] num_pass_i;
  logic [3:0] shift_i;
  logic       busy_o, done_o, err_o;

  sa_psum_accumulator_if #(.COLS(16), .ADDR_W(10)) bus ();

  sa_psum_accumulator dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .ofmap_size_i(ofmap_size_i),
    .num_pass_i(num_pass_i), .shift_i(shift_i), .sa_if(bus),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  typedef struct { logic [9:0] addr; logic [127:0] data; } beat_t;
  beat_t sb[$];
  int    mdl [16][784];
  int    errors = 0;
  int    checks = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int sat16(input int v);
    if (v > 32767) return 32767;
    else if (v < -32768) return -32768;
    else return v;
  endfunction

  function automatic logic [7:0] q8(input int e, input int sh);
    int s;
    s = e >>> sh;
    if (s > 127) s = 127;
    else if (s < -128) s = -128;
`ifdef ACC_RELU_EN
    if (s < 0) s = 0;
`endif
    return 8'(s);
  endfunction

  function automatic int gen(input int mode, input int c, input int k, input int p);
    case (mode)
      0: return k + 1 + c;
      1: return 10;
      2: return 127;
      3: return -128;
      4: return int'($urandom_range(0, 255)) - 128;
      5: return ((k * 7 + c * 3 + p * 5) % 41) - 20;
      default: return 100;
    endcase
  endfunction

  // Output monitor: every valid beat must match the scoreboard head; pop on transfer.
  always @(negedge clk) begin
    if (bus.out_valid === 1'b1) begin
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL beat_unexpected: observed addr=%0d expected=no beat", bus.out_addr);
      end
      if (sb.size() != 0) begin
        chk("beat_addr", bus.out_addr, sb[0].addr);
        chk("beat_data", bus.out_data, sb[0].data);
        if (bus.out_ready) void'(sb.pop_front());
      end
    end
  end

  task automatic run_job(input int n, input int np, input int sh, input int mode,
                         input int skew, input bit tog, input bit extra, input bit midstart);
    int    p, npe, d, k;
    bit    seen;
    beat_t b;
    p   = n * n;
    npe = (np == 0) ? 1 : np;
    bus.out_ready = 1'b1;
    start_i = 1'b1; ofmap_size_i = 5'(n); num_pass_i = 4'(np); shift_i = 4'(sh);
    @(posedge clk); #1;
    start_i = 1'b0;
    chk("busy_after_start", busy_o, 1'b1);
    chk("done_pulse_ended", done_o, 1'b0);
    chk("err_cleared", err_o, 1'b0);
    for (int ps = 0; ps < npe; ps++) begin
      for (int t = 0; t < p + 15 * skew + ((extra && ps == npe - 1) ? 1 : 0); t++) begin
        bus.accu_valid = 16'h0000;
        bus.accu_data  = 128'd0;
        for (int c = 0; c < 16; c++) begin
          k = t - c * skew;
          if (k >= 0 && k < p) begin
            d = gen(mode, c, k, ps);
            bus.accu_valid[c]       = 1'b1;
            bus.accu_data[8*c +: 8] = 8'(d);
            mdl[c][k] = (ps == 0) ? d : sat16(mdl[c][k] + d);
          end
        end
        if (extra && ps == npe - 1 && t == p) begin
          bus.accu_valid[3]     = 1'b1;
          bus.accu_data[31:24]  = 8'h63;
        end
        if (midstart && ps == 0 && t == 1) begin
          start_i = 1'b1; ofmap_size_i = 5'd3; num_pass_i = 4'd2; shift_i = 4'd5;
        end
        @(posedge clk); #1;
        start_i = 1'b0;
      end
      bus.accu_valid = 16'h0000;
      bus.accu_data  = 128'd0;
      @(posedge clk); #1;
    end
    for (int kk = 0; kk < p; kk++) begin
      b.addr = 10'(kk);
      for (int c = 0; c < 16; c++) b.data[8*c +: 8] = q8(mdl[c][kk], sh);
      sb.push_back(b);
    end
    seen = 1'b0;
    for (int i = 0; i < 4 * p + 20; i++) begin
      @(posedge clk); #1;
      if (done_o) begin seen = 1'b1; break; end
      if (tog) bus.out_ready = ~bus.out_ready;
    end
    chk("done_seen", seen, 1'b1);
    chk("all_beats_drained", sb.size(), 0);
    chk("idle_after_done", busy_o, 1'b0);
    chk("err_at_end", err_o, extra);
    sb.delete();
  endtask

  initial begin
    rst_n = 1'b0; start_i = 1'b0; ofmap_size_i = 5'd0; num_pass_i = 4'd0; shift_i = 4'd0;
    bus.accu_valid = 16'h0000; bus.accu_data = 128'd0; bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_done", done_o, 1'b0);
    chk("rst_err", err_o, 1'b0);
    chk("rst_valid", bus.out_valid, 1'b0);
    chk("rst_addr", bus.out_addr, 10'd0);
    chk("rst_data", bus.out_data, 128'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_job(2, 1, 0, 0, 0, 1'b0, 1'b0, 1'b0);   // basic ramp
    run_job(2, 3, 2, 1, 0, 1'b0, 1'b0, 1'b0);   // 3 x 10 >>> 2 = 7
    run_job(3, 2, 1, 5, 0, 1'b0, 1'b0, 1'b0);   // unskewed reference
    run_job(3, 2, 1, 5, 1, 1'b0, 1'b0, 1'b0);   // same data, skewed columns
    run_job(1, 1, 0, 2, 0, 1'b0, 1'b0, 1'b0);   // +127
    run_job(1, 2, 0, 3, 0, 1'b0, 1'b0, 1'b0);   // -256 -> -128 (or 0 rectified)
    run_job(1, 3, 0, 6, 0, 1'b0, 1'b0, 1'b0);   // 300 -> 127
    run_job(3, 3, 1, 4, 1, 1'b1, 1'b0, 1'b0);   // random, skew, backpressure
    run_job(2, 0, 0, 0, 0, 1'b1, 1'b0, 1'b0);   // num_pass 0 acts as 1

    start_i = 1'b1; ofmap_size_i = 5'd29; num_pass_i = 4'd1;
    @(posedge clk); #1;
    start_i = 1'b0;
    chk("cfg29_err", err_o, 1'b1);
    chk("cfg29_busy", busy_o, 1'b0);
    start_i = 1'b1; ofmap_size_i = 5'd0;
    @(posedge clk); #1;
    start_i = 1'b0;
    chk("cfg0_err", err_o, 1'b1);
    chk("cfg0_busy", busy_o, 1'b0);

    run_job(2, 1, 0, 4, 0, 1'b0, 1'b1, 1'b0);   // extra beat on col 3
    run_job(2, 2, 0, 5, 0, 1'b1, 1'b0, 1'b1);   // ignored start mid-ACCUM

    start_i = 1'b1; ofmap_size_i = 5'd2; num_pass_i = 4'd1; shift_i = 4'd0;
    @(posedge clk); #1;
    start_i = 1'b0;
    bus.accu_valid = 16'hffff; bus.accu_data = {16{8'h05}};
    @(posedge clk); #1;
    bus.accu_valid = 16'h0000;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst_busy", busy_o, 1'b0);
    chk("midrst_valid", bus.out_valid, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("midrst_done", done_o, 1'b0);

    run_job(2, 1, 3, 4, 0, 1'b0, 1'b0, 1'b0);   // clean job after abort
    run_job(28, 1, 0, 4, 0, 1'b0, 1'b0, 1'b0);  // full 784-entry depth

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
